// File: rtl/f_fetch_ctrl_pkg.sv
// Shared constants and types for the F-stage fetch controller:
// state encoding, reset/exception PCs and the instruction-memory window.
package f_fetch_ctrl_pkg;

    typedef enum logic [2:0] {
        FS_IDLE  = 3'd0,
        FS_REQ   = 3'd1,
        FS_DONE  = 3'd2,
        FS_ADEL  = 3'd3,
        FS_DRAIN = 3'd4
    } fstate_t;

    localparam logic [31:0] PC_RESET      = 32'h0000_3000;
    localparam logic [31:0] PC_EXC_VECTOR = 32'h0000_4180;
    localparam logic [31:0] IMEM_LO       = 32'h0000_3000;
    localparam logic [31:0] IMEM_HI       = 32'h0000_6FFC;

    // A fetch address is bad when misaligned or outside the instruction window.
    function automatic logic pc_is_bad(input logic [31:0] pc);
        return (pc[1:0] != 2'b00) || (pc < IMEM_LO) || (pc > IMEM_HI);
    endfunction

endpackage

// File: rtl/f_fetch_ctrl_pc_check.sv
// Combinational fetch-address check applied to every PC the controller loads.
module f_pc_check
    import f_fetch_ctrl_pkg::*;
(
    input  logic [31:0] pc,
    output logic        bad
);

    assign bad = pc_is_bad(pc);

endmodule

// File: rtl/f_fetch_ctrl.sv
// F-stage PC controller: owns the fetch PC, sequences req/ack fetches,
// applies exception/eret redirects and drains abandoned requests.
module f_fetch_ctrl
    import f_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = PC_RESET,
    parameter logic [31:0] EXC_VECTOR = PC_EXC_VECTOR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [31:0] npc_in,
    input  logic        jump_taken,
    input  logic        Req,
    input  logic        eret,
    input  logic [31:0] EPC,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] F_pc,
    output logic [31:0] F_instr,
    output logic        F_valid,
    output logic        F_bd,
    output logic        F_exc_adel
);

    fstate_t     state_r, state_nx;
    logic [31:0] pc_r, pc_nx;
    logic [31:0] instr_r, instr_nx;
    logic        bd_r, bd_nx;

    logic        redirect_s;
    logic [31:0] target_s;
    logic        ld_en_s;
    logic [31:0] ld_pc_s;
    logic        ld_bd_s;
    logic        ld_bad_s;

    assign redirect_s = (Req || eret) && (state_r != FS_IDLE);
    assign target_s   = Req ? EXC_VECTOR : EPC;

    f_pc_check u_pc_check (
        .pc  (ld_pc_s),
        .bad (ld_bad_s)
    );

    // Select whether this edge performs a load-PC and with which PC/BD.
    always_comb begin
        ld_en_s = 1'b0;
        ld_pc_s = pc_r;
        ld_bd_s = 1'b0;
        case (state_r)
            FS_IDLE: begin
                ld_en_s = 1'b1;
            end
            FS_REQ: begin
                if (redirect_s && imem_ack) begin
                    ld_en_s = 1'b1;
                    ld_pc_s = target_s;
                end else begin
                    ld_en_s = 1'b0;
                end
            end
            FS_DONE, FS_ADEL: begin
                if (redirect_s) begin
                    ld_en_s = 1'b1;
                    ld_pc_s = target_s;
                end else if (!stall) begin
                    ld_en_s = 1'b1;
                    ld_pc_s = npc_in;
                    ld_bd_s = jump_taken;
                end else begin
                    ld_en_s = 1'b0;
                end
            end
            FS_DRAIN: begin
                if (imem_ack) begin
                    ld_en_s = 1'b1;
                    ld_pc_s = redirect_s ? target_s : pc_r;
                end else begin
                    ld_en_s = 1'b0;
                end
            end
            default: begin
                ld_en_s = 1'b0;
            end
        endcase
    end

    // Next-state and next-datapath values.
    always_comb begin
        state_nx = state_r;
        pc_nx    = pc_r;
        bd_nx    = bd_r;
        instr_nx = instr_r;
        if (ld_en_s) begin
            pc_nx = ld_pc_s;
            bd_nx = ld_bd_s;
            if (ld_bad_s) begin
                state_nx = FS_ADEL;
                instr_nx = 32'h0000_0000;
            end else begin
                state_nx = FS_REQ;
            end
        end else begin
            case (state_r)
                FS_REQ: begin
                    // A redirect without ack leaves a response in flight that must be dropped.
                    if (redirect_s) begin
                        pc_nx    = target_s;
                        bd_nx    = 1'b0;
                        state_nx = FS_DRAIN;
                    end else if (imem_ack) begin
                        instr_nx = imem_rdata;
                        state_nx = FS_DONE;
                    end else begin
                        state_nx = FS_REQ;
                    end
                end
                FS_DRAIN: begin
                    if (redirect_s) begin
                        pc_nx = target_s;
                        bd_nx = 1'b0;
                    end else begin
                        pc_nx = pc_r;
                    end
                end
                default: begin
                    state_nx = state_r;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= FS_IDLE;
            pc_r    <= RESET_PC;
            bd_r    <= 1'b0;
            instr_r <= 32'h0000_0000;
        end else begin
            state_r <= state_nx;
            pc_r    <= pc_nx;
            bd_r    <= bd_nx;
            instr_r <= instr_nx;
        end
    end

    // Output decode from registered state only.
    always_comb begin
        imem_req   = 1'b0;
        F_valid    = 1'b0;
        F_exc_adel = 1'b0;
        case (state_r)
            FS_REQ: begin
                imem_req = 1'b1;
            end
            FS_DONE: begin
                F_valid = 1'b1;
            end
            FS_ADEL: begin
                F_valid    = 1'b1;
                F_exc_adel = 1'b1;
            end
            default: begin
                imem_req = 1'b0;
            end
        endcase
    end

    assign imem_addr = pc_r;
    assign F_pc      = pc_r;
    assign F_bd      = bd_r;
    assign F_instr   = instr_r;

endmodule

// File: tb/tb_f_fetch_ctrl.sv
// Self-checking bench for f_fetch_ctrl: directed vector table, reset corner
// sequence, and randomized traffic against a behavioural fetch model.
module tb_f_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [31:0] npc_in;
    logic        jump_taken;
    logic        Req;
    logic        eret;
    logic [31:0] EPC;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] F_pc;
    logic [31:0] F_instr;
    logic        F_valid;
    logic        F_bd;
    logic        F_exc_adel;

    int checks = 0;
    int passed = 0;

    f_fetch_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .npc_in     (npc_in),
        .jump_taken (jump_taken),
        .Req        (Req),
        .eret       (eret),
        .EPC        (EPC),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .F_pc       (F_pc),
        .F_instr    (F_instr),
        .F_valid    (F_valid),
        .F_bd       (F_bd),
        .F_exc_adel (F_exc_adel)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        jt;
        logic        req;
        logic        eret;
        logic        ack;
        logic [31:0] npc;
        logic [31:0] epc;
        logic [31:0] rdata;
        logic [31:0] e_pc;
        logic        e_valid;
        logic        e_req;
        logic        e_adel;
        logic        e_bd;
        logic [31:0] e_instr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic s, input logic j, input logic r, input logic e,
                                input logic a, input logic [31:0] n, input logic [31:0] ep,
                                input logic [31:0] rd, input logic [31:0] xpc, input logic xv,
                                input logic xr, input logic xa, input logic xb,
                                input logic [31:0] xi);
        vec_t v;
        v.stall = s; v.jt = j; v.req = r; v.eret = e; v.ack = a;
        v.npc = n; v.epc = ep; v.rdata = rd;
        v.e_pc = xpc; v.e_valid = xv; v.e_req = xr; v.e_adel = xa; v.e_bd = xb; v.e_instr = xi;
        return v;
    endfunction

    task automatic check_out(input string name, input logic [31:0] e_pc, input logic e_valid,
                             input logic e_req, input logic e_adel, input logic e_bd,
                             input logic [31:0] e_instr);
        checks++;
        if (F_pc === e_pc && imem_addr === e_pc && F_valid === e_valid && imem_req === e_req &&
            F_exc_adel === e_adel && F_bd === e_bd && F_instr === e_instr) begin
            passed++;
        end else begin
            $display("FAIL %s @%0t: got pc=%h addr=%h valid=%b req=%b adel=%b bd=%b instr=%h; want pc=%h valid=%b req=%b adel=%b bd=%b instr=%h",
                     name, $time, F_pc, imem_addr, F_valid, imem_req, F_exc_adel, F_bd, F_instr,
                     e_pc, e_valid, e_req, e_adel, e_bd, e_instr);
        end
    endtask

    task automatic clear_inputs();
        stall = 1'b0; jump_taken = 1'b0; Req = 1'b0; eret = 1'b0; imem_ack = 1'b0;
        npc_in = 32'h0; EPC = 32'h0; imem_rdata = 32'h0;
    endtask

    // Behavioural model: what the F stage holds and what the memory still owes it.
    logic [31:0] m_pc, m_instr;
    logic        m_bd;
    logic        m_started;
    logic        m_wait;
    logic        m_drain;
    logic        m_hold;
    logic        m_adel;

    function automatic bit addr_bad(input logic [31:0] p);
        return (p % 4 != 0) || (p < 32'h0000_3000) || (p > 32'h0000_6FFC);
    endfunction

    task automatic model_reset();
        m_pc = 32'h0000_3000; m_instr = 32'h0; m_bd = 1'b0;
        m_started = 1'b0; m_wait = 1'b0; m_drain = 1'b0; m_hold = 1'b0; m_adel = 1'b0;
    endtask

    task automatic model_load(input logic [31:0] p, input logic b);
        m_pc = p; m_bd = b;
        m_wait = 1'b0; m_drain = 1'b0; m_hold = 1'b0; m_adel = 1'b0;
        if (addr_bad(p)) begin
            m_adel  = 1'b1;
            m_instr = 32'h0;
        end else begin
            m_wait = 1'b1;
        end
    endtask

    task automatic model_step();
        logic        redir;
        logic [31:0] tgt;
        redir = m_started && (Req || eret);
        tgt   = Req ? 32'h0000_4180 : EPC;
        if (!m_started) begin
            m_started = 1'b1;
            model_load(m_pc, 1'b0);
        end else if (redir) begin
            if ((m_wait || m_drain) && !imem_ack) begin
                m_pc = tgt; m_bd = 1'b0; m_wait = 1'b0; m_drain = 1'b1;
            end else begin
                model_load(tgt, 1'b0);
            end
        end else if (m_wait) begin
            if (imem_ack) begin
                m_instr = imem_rdata; m_wait = 1'b0; m_hold = 1'b1;
            end
        end else if (m_drain) begin
            if (imem_ack) model_load(m_pc, 1'b0);
        end else if (!stall) begin
            model_load(npc_in, jump_taken);
        end
    endtask

    function automatic logic [31:0] rand_pc();
        if ($urandom_range(0, 9) == 0) return $urandom;
        return 32'h0000_3000 + 32'($urandom_range(0, 4095)) * 32'd4;
    endfunction

    initial begin
        clear_inputs();
        reset = 1'b1;
        #12;
        check_out("reset_values", 32'h3000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

        // Directed vector table: inputs for one edge and outputs expected after it.
        vecs.push_back(mk(0,0,0,0,0, 32'h0,    32'h0,    32'h0,         32'h3000, 0,1,0,0, 32'h0));
        vecs.push_back(mk(0,0,0,0,1, 32'h0,    32'h0,    32'hA000_0000, 32'h3000, 1,0,0,0, 32'hA000_0000));
        vecs.push_back(mk(0,0,0,0,0, 32'h3004, 32'h0,    32'h0,         32'h3004, 0,1,0,0, 32'hA000_0000));
        vecs.push_back(mk(0,0,0,0,1, 32'h0,    32'h0,    32'hA000_0001, 32'h3004, 1,0,0,0, 32'hA000_0001));
        vecs.push_back(mk(0,0,0,0,0, 32'h3008, 32'h0,    32'h0,         32'h3008, 0,1,0,0, 32'hA000_0001));
        vecs.push_back(mk(0,0,0,0,1, 32'h0,    32'h0,    32'hA000_0002, 32'h3008, 1,0,0,0, 32'hA000_0002));
        vecs.push_back(mk(1,0,0,0,0, 32'h300C, 32'h0,    32'h0,         32'h3008, 1,0,0,0, 32'hA000_0002));
        vecs.push_back(mk(1,0,0,0,0, 32'h300C, 32'h0,    32'h0,         32'h3008, 1,0,0,0, 32'hA000_0002));
        vecs.push_back(mk(1,0,0,0,0, 32'h300C, 32'h0,    32'h0,         32'h3008, 1,0,0,0, 32'hA000_0002));
        vecs.push_back(mk(0,1,0,0,0, 32'h300C, 32'h0,    32'h0,         32'h300C, 0,1,0,1, 32'hA000_0002));
        vecs.push_back(mk(0,0,0,0,1, 32'h0,    32'h0,    32'hA000_0003, 32'h300C, 1,0,0,1, 32'hA000_0003));
        vecs.push_back(mk(0,0,1,0,0, 32'h0,    32'h0,    32'h0,         32'h4180, 0,1,0,0, 32'hA000_0003));
        vecs.push_back(mk(0,0,1,1,0, 32'h0,    32'h3010, 32'h0,         32'h4180, 0,0,0,0, 32'hA000_0003));
        vecs.push_back(mk(0,0,0,0,0, 32'h0,    32'h0,    32'h0,         32'h4180, 0,0,0,0, 32'hA000_0003));
        vecs.push_back(mk(0,0,0,0,1, 32'h0,    32'h0,    32'hDEAD_BEEF, 32'h4180, 0,1,0,0, 32'hA000_0003));
        vecs.push_back(mk(0,0,0,0,1, 32'h0,    32'h0,    32'hA000_0004, 32'h4180, 1,0,0,0, 32'hA000_0004));
        vecs.push_back(mk(0,0,0,0,0, 32'h3002, 32'h0,    32'h0,         32'h3002, 1,0,1,0, 32'h0));
        vecs.push_back(mk(1,0,0,0,0, 32'h3002, 32'h0,    32'h0,         32'h3002, 1,0,1,0, 32'h0));
        vecs.push_back(mk(0,0,0,1,0, 32'h0,    32'h3000, 32'h0,         32'h3000, 0,1,0,0, 32'h0));
        vecs.push_back(mk(0,0,0,0,1, 32'h0,    32'h0,    32'hA000_0005, 32'h3000, 1,0,0,0, 32'hA000_0005));
        vecs.push_back(mk(0,0,0,0,0, 32'h7000, 32'h0,    32'h0,         32'h7000, 1,0,1,0, 32'h0));
        vecs.push_back(mk(0,0,0,1,0, 32'h0,    32'h3000, 32'h0,         32'h3000, 0,1,0,0, 32'h0));
        vecs.push_back(mk(0,0,0,0,1, 32'h0,    32'h0,    32'hA000_0006, 32'h3000, 1,0,0,0, 32'hA000_0006));
        vecs.push_back(mk(0,0,0,0,0, 32'h6FFC, 32'h0,    32'h0,         32'h6FFC, 0,1,0,0, 32'hA000_0006));
        vecs.push_back(mk(0,0,0,0,1, 32'h0,    32'h0,    32'hA000_0007, 32'h6FFC, 1,0,0,0, 32'hA000_0007));
        vecs.push_back(mk(0,0,0,0,0, 32'h2FFC, 32'h0,    32'h0,         32'h2FFC, 1,0,1,0, 32'h0));

        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            stall = vecs[i].stall; jump_taken = vecs[i].jt; Req = vecs[i].req;
            eret = vecs[i].eret; imem_ack = vecs[i].ack; npc_in = vecs[i].npc;
            EPC = vecs[i].epc; imem_rdata = vecs[i].rdata;
            @(posedge clk);
            @(negedge clk);
            check_out($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_valid, vecs[i].e_req,
                      vecs[i].e_adel, vecs[i].e_bd, vecs[i].e_instr);
        end

        // Reset taken in the middle of an outstanding fetch.
        clear_inputs();
        EPC = 32'h0000_5000;
        eret = 1'b1;
        @(negedge clk);
        eret = 1'b0;
        check_out("eret_to_req", 32'h5000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        #2;
        reset = 1'b1;
        #1;
        check_out("async_reset_midfetch", 32'h3000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        check_out("idle_after_reset", 32'h3000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check_out("first_req_after_reset", 32'h3000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);

        // Randomized traffic against the model.
        @(negedge clk);
        reset = 1'b1;
        clear_inputs();
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            check_out("random", m_pc, m_hold || m_adel, m_wait, m_adel, m_bd, m_instr);
            stall      = ($urandom_range(0, 2) == 0);
            jump_taken = ($urandom_range(0, 3) == 0);
            Req        = ($urandom_range(0, 19) == 0);
            eret       = ($urandom_range(0, 14) == 0);
            npc_in     = rand_pc();
            EPC        = rand_pc();
            imem_ack   = (m_wait || m_drain) && ($urandom_range(0, 1) == 1);
            imem_rdata = $urandom;
            @(posedge clk);
            model_step();
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/f_fetch_ctrl.md
# f_fetch_ctrl

Fetch-stage PC controller for the pipelined MIPS core. It owns the F-stage PC register and sequences instruction fetch over a variable-latency req/ack instruction-memory port. It applies exception-entry and eret redirects, tracks the delay-slot (BD) attribute of the fetched instruction, and flags address-error fetches. It sits between the D-stage next-PC logic, which supplies `npc_in`, and the F/D pipeline register.

## Interface
- `RESET_PC`, 32'h0000_3000, PC loaded by reset.
- `EXC_VECTOR`, 32'h0000_4180, PC loaded on exception entry.
- `clk`  in  1  single clock; everything is on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `stall`  in  1  hazard-unit stall; F/D must not advance.
- `npc_in`  in  32  next PC from the D-stage next-PC logic.
- `jump_taken`  in  1  D instruction is a branch/jump, so the next fetched instruction is a delay slot.
- `Req`  in  1  exception request from M stage.
- `eret`  in  1  eret redirect.
- `EPC`  in  32  eret target.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address; equals `F_pc`.
- `imem_ack`  in  1  data valid on `imem_rdata`.
- `imem_rdata`  in  32  instruction word.
- `F_pc`  out  32  PC of the F instruction.
- `F_instr`  out  32  latched instruction.
- `F_valid`  out  1  `F_instr`/`F_pc` are presentable to D.
- `F_bd`  out  1  F instruction is in a delay slot.
- `F_exc_adel`  out  1  fetch address error.

## Operation
- **States:**
  - `S_IDLE` is the reset state.
  - `S_REQ` waits for `imem_ack`.
  - `S_DONE` holds the fetched instruction.
  - `S_ADEL` holds a bad-address token.
  - `S_DRAIN` discards the ack of an abandoned request.
- **Outputs per state:**
  - `imem_req` = (state == `S_REQ`).
  - `F_valid` = state ∈ {`S_DONE`, `S_ADEL`}.
  - `F_exc_adel` = (state == `S_ADEL`).
- **Address check:** a PC is bad if `pc[1:0]`≠0 or the PC lies outside 0x0000_3000..0x0000_6FFC inclusive. This check is applied to every new PC.
- **Load-PC action** (new PC `p`, new BD value `b`): `F_pc`←`p`, `F_bd`←`b`, then go to `S_ADEL` if `p` is bad, else to `S_REQ`.
- **`S_IDLE`:** the next edge performs load-PC(`F_pc`, 0).
- **`S_REQ`:** on `imem_ack`, `F_instr`←`imem_rdata`, go to `S_DONE`.
- **`S_DONE` / `S_ADEL`:** if !`stall`, perform load-PC(`npc_in`, `jump_taken`). On entering `S_ADEL`, `F_instr`←0 (nop).
- **Redirect** (`Req` or `eret`) overrides everything above, in any state except `S_IDLE`, regardless of `stall`:
  - The target is `EXC_VECTOR` if `Req`, else `EPC`. `Req` wins when both are asserted.
  - `F_bd`←0.
  - If state is `S_REQ` and `imem_ack`=0, `F_pc`←target and go to `S_DRAIN`. The outstanding response must be discarded.
  - Otherwise perform load-PC(target, 0).
- **`S_DRAIN`:**
  - `imem_req`=0, and the ack is discarded (`F_instr` unchanged).
  - On `imem_ack`, perform load-PC(`F_pc`, 0).
  - A further redirect in `S_DRAIN` updates `F_pc` and remains in `S_DRAIN`.
  - If ack and redirect coincide, perform load-PC(new target, 0).
- The instruction memory is reset by the same `reset`, so no ack is pending after reset.

## Timing
- **Reset values:**
  - `F_pc`=`RESET_PC`, `F_instr`=0.
  - `F_valid`=0, `F_bd`=0, `F_exc_adel`=0, `imem_req`=0.
  - State=`S_IDLE`.
- Reset asserted mid-fetch returns to these values immediately; the in-flight request is abandoned.
- The first `imem_req` is asserted one cycle after reset deasserts.
- **Fetch latency:** request cycle n with ack in cycle n+k (k≥0) gives `F_valid`=1 in cycle n+k+1.
- The minimum issue interval is 2 cycles per instruction.
- `imem_req` and `imem_addr` are stable until ack.
- A redirect takes effect at the edge where it is sampled; the new `F_pc` is visible the following cycle.
- `F_valid` drops to 0 that same following cycle; D must insert a bubble.
- All outputs are combinational from registered state only (no input-to-output paths).

## Structure
- Shared constants go in `macro.v`:
  - state encodings `FS_IDLE`/`FS_REQ`/`FS_DONE`/`FS_ADEL`/`FS_DRAIN`;
  - `PC_RESET`, `PC_EXC_VECTOR`;
  - `IMEM_LO` = 0x3000, `IMEM_HI` = 0x6FFC.
- One sub-module, `f_pc_check`: combinational `pc` → `bad` address check, instantiated for the load-PC target.

## Test plan
- Reset, then ack in the same cycle as each request, `stall`=0, `npc_in`=`F_pc`+4 -> `F_pc` sequence 0x3000, 0x3004, 0x3008, with `F_valid` high every second cycle.
- In `S_DONE`, hold `stall` for 3 cycles -> `F_pc`, `F_instr` and `F_valid`=1 are unchanged; release -> `F_pc` takes `npc_in`.
- Assert `jump_taken`=1 on the advance edge -> the next instruction has `F_bd`=1. Then assert `Req` -> `F_pc`=0x4180, `F_bd`=0.
- Assert `Req` and `eret` (`EPC`=0x3010) during `S_REQ` with ack delayed 2 cycles -> enters `S_DRAIN`, the late ack is discarded, the next request is to 0x4180, and `F_instr` is not the stale word.
- Drive `npc_in`=0x3002, then (after reset) 0x7000 -> `F_exc_adel`=1, `F_valid`=1, `F_instr`=0, no `imem_req`. `eret` to `EPC`=0x3000 recovers.
- Assert `reset` while in `S_REQ` -> all outputs take reset values immediately; after release, `imem_req` returns with `imem_addr`=0x3000.
